// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: sequences write, read and auto-refresh bursts onto one SDRAM command port.
// Optional ARB_RR_EN: round-robin between write and read instead of fixed write > read priority.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 9,
  parameter int REF_CYC = 780
) (
  input  logic              sd_clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_ack,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  output logic              rd_done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              ref_overrun
);
  localparam int CNT_W = $clog2(REF_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_CYC - 1);
  localparam logic [1:0] T_WR = 2'b00, T_RD = 2'b01, T_REF = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] ref_cnt;
  logic ref_pend, expire, ref_clr;
  logic wr_v, rd_v, wr_first, go, pick_ref, pick_wr, pick_rd;
  logic wr_zero, rd_zero, wr_go, rd_go, issue, hs, fin;
  logic cmd_valid_nxt, wr_ack_nxt, wr_done_nxt, rd_ack_nxt, rd_done_nxt;
  logic [1:0] cmd_type_nxt;
  logic [ADDR_W-1:0] cmd_addr_nxt;
  logic [LEN_W-1:0] cmd_len_nxt;
  // a requester still sees its own req high during its ack cycle, so mask it then
  assign wr_v     = wr_req & ~wr_ack;
  assign rd_v     = rd_req & ~rd_ack;
  assign go       = (state == IDLE) & init_done;
  assign pick_ref = go & ref_pend;
  assign pick_wr  = go & ~ref_pend & wr_v & (~rd_v | wr_first);
  assign pick_rd  = go & ~ref_pend & rd_v & ~(wr_v & wr_first);
  assign wr_zero  = pick_wr & (wr_len == '0);
  assign rd_zero  = pick_rd & (rd_len == '0);
  assign wr_go    = pick_wr & ~wr_zero;
  assign rd_go    = pick_rd & ~rd_zero;
  assign issue    = pick_ref | wr_go | rd_go;
  assign hs       = (state == ISSUE) & cmd_ready;
  assign fin      = (state == BUSY) & cmd_done;
  assign expire   = init_done & (ref_cnt == '0);
  assign ref_clr  = fin & (cmd_type == T_REF);
`ifdef ARB_RR_EN
  logic last_rd;
  // last-owner bit starts at read so the first contention goes to write; refresh leaves it alone
  always_ff @(posedge sd_clk or negedge rst_n)
    if (!rst_n) last_rd <= 1'b1;
    else if (pick_wr | pick_rd) last_rd <= pick_rd;
  assign wr_first = last_rd;
`else
  assign wr_first = 1'b1;
`endif
  // refresh interval timer; pending flag survives until the refresh command completes
  always_ff @(posedge sd_clk or negedge rst_n)
    if (!rst_n) begin
      ref_cnt     <= CNT_MAX;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (init_done) ref_cnt <= expire ? CNT_MAX : ref_cnt - CNT_W'(1);
      ref_pend    <= expire | (ref_pend & ~ref_clr);
      ref_overrun <= ref_overrun | (expire & ref_pend);
    end
  // state and registered outputs
  always_ff @(posedge sd_clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_type  <= T_WR;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      wr_ack    <= 1'b0;
      wr_done   <= 1'b0;
      rd_ack    <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_type  <= cmd_type_nxt;
      cmd_addr  <= cmd_addr_nxt;
      cmd_len   <= cmd_len_nxt;
      wr_ack    <= wr_ack_nxt;
      wr_done   <= wr_done_nxt;
      rd_ack    <= rd_ack_nxt;
      rd_done   <= rd_done_nxt;
    end
  // next state: one command in flight at a time
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = issue ? ISSUE : IDLE;
      ISSUE:   state_nxt = cmd_ready ? BUSY : ISSUE;
      BUSY:    state_nxt = cmd_done ? IDLE : BUSY;
      default: state_nxt = IDLE;
    endcase
  end
  // next output values; cmd_type doubles as the owner record
  always_comb begin
    cmd_valid_nxt = state_nxt == ISSUE;
    cmd_type_nxt  = pick_ref ? T_REF : wr_go ? T_WR : rd_go ? T_RD : cmd_type;
    cmd_addr_nxt  = pick_ref ? '0 : wr_go ? wr_addr : rd_go ? rd_addr : cmd_addr;
    cmd_len_nxt   = pick_ref ? '0 : wr_go ? wr_len : rd_go ? rd_len : cmd_len;
    wr_ack_nxt    = wr_zero | (hs & (cmd_type == T_WR));
    wr_done_nxt   = wr_zero | (fin & (cmd_type == T_WR));
    rd_ack_nxt    = rd_zero | (hs & (cmd_type == T_RD));
    rd_done_nxt   = rd_zero | (fin & (cmd_type == T_RD));
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Sequences the single SDRAM controller command port between the QSPI capture writer (write requester), the USB readout path (read requester) and an internal auto-refresh timer. Sits in the `sd_clk` domain between the requester FIFOs and the SDRAM command engine inside `qspi_simulator_top`. Issues one burst command at a time and tracks its completion. Owns refresh scheduling so that neither requester has to know about it.

## Interface
Parameters:
- `ADDR_W`, 24, SDRAM word address width.
- `LEN_W`, 9, burst length width in 16-bit words.
- `REF_CYC`, 780, `sd_clk` cycles between refresh requests (7.8 us at 100 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `sd_clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `init_done` in 1: SDRAM power-up sequence complete; no command is issued while low.
- `wr_req` in 1: write requester wants a burst.
- `wr_addr` in ADDR_W: write start address.
- `wr_len` in LEN_W: write length.
- `wr_ack` out 1: one-cycle pulse when the write command is accepted downstream.
- `wr_done` out 1: one-cycle pulse when the write burst completes.
- `rd_req`, `rd_addr`, `rd_len`, `rd_ack`, `rd_done`: same as the write set, for the read requester.
- `cmd_valid` out 1: command present.
- `cmd_ready` in 1: controller accepts the command.
- `cmd_type` out 2: 00 write, 01 read, 10 refresh.
- `cmd_addr` out ADDR_W: command address.
- `cmd_len` out LEN_W: command length.
- `cmd_done` in 1: one-cycle pulse from the controller when the current command is finished.
- `ref_overrun` out 1: sticky flag, a refresh interval expired while the previous refresh was still pending.

## Operation
- **FSM states:** IDLE, ISSUE, BUSY.
- **IDLE:**
  - With `init_done`=1, select a source by priority: refresh pending > write > read.
  - Latch the winner's type, address and length into the `cmd_*` registers, record the owner, and go to ISSUE.
  - With nothing pending, stay in IDLE.
- **ISSUE:**
  - Hold `cmd_valid`=1 with stable `cmd_*` until `cmd_ready`.
  - On handshake: pulse `wr_ack` or `rd_ack` for the owner (nothing for refresh), clear `cmd_valid`, go to BUSY.
- **BUSY:**
  - Wait for `cmd_done`.
  - On `cmd_done`: pulse `wr_done` or `rd_done` for the owner (refresh clears `ref_pend`), go to IDLE.
- **Requester rule:** a requester holds `req`, `addr` and `len` stable until its `ack`. It deasserts `req` or presents the next burst in the cycle after `ack`.
- **Zero-length request:** `len`=0 issues no command. In IDLE it produces `ack` and `done` in the same cycle, then stays in IDLE.
- **Refresh timer:**
  - Down-counter loaded with REF_CYC-1. It runs only while `init_done`=1.
  - At 0: set `ref_pend` and reload.
  - If `ref_pend` is already set at expiry: set `ref_overrun` (cleared only by reset).
  - Refresh never preempts a burst. It wins at the next IDLE.
- **Dropped request:** a request deasserted before selection is simply not served.
- **`init_done` falling** in ISSUE or BUSY: the current command completes normally. New selection waits for `init_done`=1.
- **Reset mid-operation:** everything clears immediately and `cmd_valid` drops asynchronously. The controller shares `rst_n`, so no orphaned `cmd_done` is expected. A spurious `cmd_done` in IDLE is ignored.

## Timing
- All outputs are registered.
- **Reset values:** `cmd_valid`=0, `cmd_type`=00, `cmd_addr`=0, `cmd_len`=0, all `ack`/`done`=0, `ref_overrun`=0, FSM=IDLE, timer=REF_CYC-1, `ref_pend`=0.
- **Issue latency:** request sampled in IDLE at cycle N gives `cmd_valid`=1 at N+1.
- **Ack timing:** `cmd_ready` at cycle M gives `ack` at M+1 and `cmd_valid`=0 at M+1.
- **Done timing:** `cmd_done` at cycle K gives `done` at K+1 and IDLE at K+1. The next `cmd_valid` is no earlier than K+2.
- **Throughput:** minimum 3 cycles per command plus controller time.
- **Simultaneous events:**
  - Refresh expiry in the same cycle as an IDLE selection: the already-pending set wins. The new refresh waits one round.
  - `wr_req` and `rd_req` in the same cycle: write wins (default policy).

## Configuration
- `ARB_RR_EN`:
  - **Defined:** write and read alternate round-robin. A last-owner bit (reset = read, so write wins first) gives priority to the other requester when both are pending. Refresh keeps top priority and does not update last-owner.
  - **Undefined:** fixed priority write > read. A continuous write stream can starve reads; this is intended, because the QSPI capture path must not overflow.

## Test plan
- **Init gating:** `init_done`=0, `wr_req`=1 for 100 cycles -> no `cmd_valid`. Raise `init_done` -> write command `addr`=0x000100, `len`=256 issued 1 cycle later; `wr_ack` and `wr_done` each pulse once.
- **Contention:** `wr_req` and `rd_req` held continuously. Without `ARB_RR_EN`: only writes are issued. With `ARB_RR_EN`: `cmd_type` sequence is 00,01,00,01.
- **Refresh:** `REF_CYC`=50, controller holds `cmd_done` off for 200 cycles on a write -> `ref_overrun`=1. After `done`, the next command is `cmd_type`=10, ahead of a pending read.
- **Zero length:** `rd_req` with `len`=0 -> `rd_ack` and `rd_done` in the same cycle, `cmd_valid` stays 0.
- **Reset mid-burst:** assert `rst_n`=0 during BUSY -> `cmd_valid`=0 and all pulses 0 immediately. After release, the next request is served normally.
- **Backpressure:** `cmd_ready` low for 10 cycles -> `cmd_valid`, `cmd_addr` and `cmd_len` stable throughout; `ack` exactly 1 cycle after the handshake.
